// File: rtl/tc_bus_bridge_pkg.sv
// Shared types and constants for the CPU-to-timer bus bridge.
package tc_bus_bridge_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned HWINT_W    = 6;
  localparam int unsigned SLOT_BYTES = 16;

  localparam logic [1:0] REG_TC_CTRL   = 2'd0;
  localparam logic [1:0] REG_TC_PRESET = 2'd1;
  localparam logic [1:0] REG_TC_COUNT  = 2'd2;
  localparam logic [1:0] REG_PEND      = 2'd0;
  localparam logic [1:0] REG_MASK      = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    TGT_NONE  = 2'd0,
    TGT_TIMER = 2'd1,
    TGT_IRQ   = 2'd2
  } tgt_e;

  // Decoded request latched when the bridge accepts an access.
  typedef struct packed {
    tgt_e       tgt;
    logic       we;
    logic [2:0] slot;
    logic [1:0] word;
  } req_t;

endpackage

// File: rtl/tc_bus_bridge_irq_unit.sv
// Interrupt unit: timer IRQ edge capture into PEND, MASK register and
// registered hardware-interrupt outputs.
module tc_bus_bridge_irq_unit
  import tc_bus_bridge_pkg::*;
#(
  parameter int unsigned NDEV = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NDEV-1:0]    irq_i,
  input  logic               pend_wr_i,
  input  logic               mask_wr_i,
  input  logic [NDEV-1:0]    wr_bits_i,
  input  logic [NDEV-1:0]    wr_en_i,
  output logic [NDEV-1:0]    pend_o,
  output logic [NDEV-1:0]    mask_o,
  output logic [HWINT_W-1:0] hwint_o
);

  logic [NDEV-1:0]    irq_q;
  logic [NDEV-1:0]    pend_q;
  logic [NDEV-1:0]    pend_d;
  logic [NDEV-1:0]    mask_q;
  logic [NDEV-1:0]    mask_d;
  logic [NDEV-1:0]    rise;
  logic [HWINT_W-1:0] hwint_q;

  assign rise = irq_i & ~irq_q;

  // A rising edge in the same cycle as a write-1-to-clear keeps the bit set.
  always_comb begin
    pend_d = pend_q;
    mask_d = mask_q;
    if (pend_wr_i) begin
      pend_d = pend_q & ~(wr_bits_i & wr_en_i);
    end
    pend_d = pend_d | rise;
    if (mask_wr_i) begin
      mask_d = (mask_q & ~wr_en_i) | (wr_bits_i & wr_en_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_q   <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
      hwint_q <= '0;
    end else begin
      irq_q   <= irq_i;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      hwint_q <= HWINT_W'(pend_q & mask_q);
    end
  end

  assign pend_o  = pend_q;
  assign mask_o  = mask_q;
  assign hwint_o = hwint_q;

endmodule

// File: rtl/tc_bus_bridge.sv
// CPU data-port bridge to NDEV timer slots plus an interrupt-unit slot:
// decode, one-cycle write strobe, registered read data and ack.
module tc_bus_bridge
  import tc_bus_bridge_pkg::*;
#(
  parameter logic [31:0] BASE = 32'h0000_7F00,
  parameter int unsigned NDEV = 2
) (
  input  logic                   CLK_I,
  input  logic                   RST_I,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [31:0]            cpu_addr,
  input  logic [3:0]             cpu_be,
  input  logic [DATA_W-1:0]      cpu_wdata,
  output logic [DATA_W-1:0]      cpu_rdata,
  output logic                   cpu_ack,
  output logic                   cpu_err,
  output logic [HWINT_W-1:0]     cpu_hwint,
  output logic [1:0]             dev_add,
  output logic [3:0]             dev_be,
  output logic [DATA_W-1:0]      dev_wdata,
  output logic [NDEV-1:0]        dev_we,
  input  logic [DATA_W*NDEV-1:0] dev_rdata,
  input  logic [NDEV-1:0]        dev_irq
);

  localparam int unsigned WIN_BYTES = SLOT_BYTES * (NDEV + 1);

  state_e            state_q;
  req_t              req_d;
  req_t              req_q;
  logic [31:0]       off;
  logic [1:0]        dev_add_q;
  logic [3:0]        dev_be_q;
  logic [DATA_W-1:0] dev_wdata_q;
  logic [NDEV-1:0]   dev_we_q;
  logic              ack_q;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rd_mux;
  logic              irq_wr;
  logic [NDEV-1:0]   wr_en;
  logic [NDEV-1:0]   pend;
  logic [NDEV-1:0]   mask;

  assign off = cpu_addr - BASE;

  // Window is at most 112 bytes, so off[6:4] is the slot once inside it.
  always_comb begin
    req_d      = '0;
    req_d.tgt  = TGT_NONE;
    req_d.we   = cpu_we;
    req_d.slot = off[6:4];
    req_d.word = off[3:2];
    if (off < 32'(WIN_BYTES)) begin
      if (off[6:4] < 3'(NDEV)) begin
        if (off[3:2] inside {REG_TC_CTRL, REG_TC_PRESET, REG_TC_COUNT}) begin
          req_d.tgt = TGT_TIMER;
        end
      end else if (off[3:2] == REG_PEND || off[3:2] == REG_MASK) begin
        req_d.tgt = TGT_IRQ;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    if (!req_q.we) begin
      if (req_q.tgt == TGT_TIMER) begin
        for (int k = 0; k < int'(NDEV); k++) begin
          if (req_q.slot == 3'(k)) begin
            rd_mux = dev_rdata[DATA_W*k +: DATA_W];
          end
        end
      end else if (req_q.tgt == TGT_IRQ) begin
        rd_mux = (req_q.word == REG_PEND) ? DATA_W'(pend) : DATA_W'(mask);
      end
    end
  end

  // Per-bit write enables for PEND/MASK from the latched byte enables.
  always_comb begin
    wr_en = '0;
    for (int k = 0; k < int'(NDEV); k++) begin
      wr_en[k] = dev_be_q[k / 8];
    end
  end

  assign irq_wr = (state_q == ST_XFER) && (req_q.tgt == TGT_IRQ) && req_q.we;

  tc_bus_bridge_irq_unit #(
    .NDEV (NDEV)
  ) u_irq_unit (
    .clk_i     (CLK_I),
    .rst_i     (RST_I),
    .irq_i     (dev_irq),
    .pend_wr_i (irq_wr && (req_q.word == REG_PEND)),
    .mask_wr_i (irq_wr && (req_q.word == REG_MASK)),
    .wr_bits_i (dev_wdata_q[NDEV-1:0]),
    .wr_en_i   (wr_en),
    .pend_o    (pend),
    .mask_o    (mask),
    .hwint_o   (cpu_hwint)
  );

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      dev_add_q   <= '0;
      dev_be_q    <= '0;
      dev_wdata_q <= '0;
      dev_we_q    <= '0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      ack_q    <= 1'b0;
      dev_we_q <= '0;
      unique case (state_q)
        ST_IDLE: begin
          if (cpu_req) begin
            req_q       <= req_d;
            dev_add_q   <= req_d.word;
            dev_be_q    <= cpu_be;
            dev_wdata_q <= cpu_wdata;
            if (req_d.tgt == TGT_TIMER && cpu_we) begin
              dev_we_q <= NDEV'(1) << req_d.slot;
            end
            state_q <= ST_XFER;
          end
        end
        ST_XFER: begin
          ack_q   <= 1'b1;
          err_q   <= (req_q.tgt == TGT_NONE);
          rdata_q <= rd_mux;
          state_q <= ST_ACK;
        end
        ST_ACK: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign cpu_ack   = ack_q;
  assign cpu_err   = err_q;
  assign cpu_rdata = rdata_q;
  assign dev_add   = dev_add_q;
  assign dev_be    = dev_be_q;
  assign dev_wdata = dev_wdata_q;
  assign dev_we    = dev_we_q;

endmodule

// File: tb/tb_tc_bus_bridge.sv
// Self-checking bench for tc_bus_bridge: directed scenarios plus random
// accesses checked against an address-map/interrupt reference model.
module tb_tc_bus_bridge;

  localparam int unsigned NDEV = 2;
  localparam logic [31:0] BASE = 32'h0000_7F00;

  logic                 CLK_I     = 1'b0;
  logic                 RST_I     = 1'b1;
  logic                 cpu_req   = 1'b0;
  logic                 cpu_we    = 1'b0;
  logic [31:0]          cpu_addr  = '0;
  logic [3:0]           cpu_be    = '0;
  logic [31:0]          cpu_wdata = '0;
  logic [31:0]          cpu_rdata;
  logic                 cpu_ack;
  logic                 cpu_err;
  logic [5:0]           cpu_hwint;
  logic [1:0]           dev_add;
  logic [3:0]           dev_be;
  logic [31:0]          dev_wdata;
  logic [NDEV-1:0]      dev_we;
  logic [32*NDEV-1:0]   dev_rdata = '0;
  logic [NDEV-1:0]      dev_irq   = '0;

  int checks = 0;
  int errors = 0;

  logic [31:0]     obs_rd;
  logic            obs_err;
  int              obs_ack_cyc;
  int              obs_we_cnt;
  logic [NDEV-1:0] obs_we_val;
  logic [1:0]      obs_add;
  logic [31:0]     obs_wdata;

  tc_bus_bridge #(.BASE(BASE), .NDEV(NDEV)) dut (
    .CLK_I     (CLK_I),
    .RST_I     (RST_I),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_be    (cpu_be),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ack   (cpu_ack),
    .cpu_err   (cpu_err),
    .cpu_hwint (cpu_hwint),
    .dev_add   (dev_add),
    .dev_be    (dev_be),
    .dev_wdata (dev_wdata),
    .dev_we    (dev_we),
    .dev_rdata (dev_rdata),
    .dev_irq   (dev_irq)
  );

  always #5 CLK_I = ~CLK_I;

  // One CPU access from IDLE; cycle c counts edges after cpu_req rises (c=1 is the accept edge).
  task automatic bus_access(input logic we, input logic [31:0] addr, input logic [3:0] be,
                            input logic [31:0] wd, input int irq_cyc, input logic [NDEV-1:0] irq_val);
    obs_ack_cyc = 0; obs_we_cnt = 0; obs_we_val = '0; obs_add = '0; obs_rd = '0;
    obs_err = 1'b0; obs_wdata = '0;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_be = be; cpu_wdata = wd;
    for (int c = 1; c <= 8 && obs_ack_cyc == 0; c++) begin
      @(posedge CLK_I); #1;
      if (c == 1) obs_add = dev_add;
      if (dev_we !== '0) begin
        obs_we_cnt++; obs_we_val = dev_we; obs_wdata = dev_wdata;
      end
      if (c == irq_cyc) dev_irq = irq_val;
      if (cpu_ack === 1'b1) begin
        obs_ack_cyc = c; obs_rd = cpu_rdata; obs_err = cpu_err;
      end
    end
    cpu_req = 1'b0;
    checks++;
    if (obs_ack_cyc == 0) begin
      errors++; $display("FAIL ack_timeout addr=%h got no ack within 8 cycles", addr);
    end
    @(posedge CLK_I); #1;
    if (dev_we !== '0) obs_we_cnt++;
  endtask

  task automatic test_reset();
    RST_I = 1'b1;
    repeat (3) @(posedge CLK_I);
    #1;
    checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0", cpu_ack); end
    checks++; if (cpu_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", cpu_err); end
    checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", cpu_rdata); end
    checks++; if (dev_we !== '0) begin errors++; $display("FAIL reset_dev_we got=%b exp=0", dev_we); end
    checks++; if (cpu_hwint !== 6'h0) begin errors++; $display("FAIL reset_hwint got=%b exp=0", cpu_hwint); end
    RST_I = 1'b0;
  endtask

  task automatic test_timer_write();
    bus_access(1'b1, 32'h0000_7F00, 4'hF, 32'h0000_0009, -1, '0);
    checks++; if (obs_we_cnt != 1) begin errors++; $display("FAIL twr_we_cycles got=%0d exp=1", obs_we_cnt); end
    checks++; if (obs_we_val !== 2'b01) begin errors++; $display("FAIL twr_we_val got=%b exp=01", obs_we_val); end
    checks++; if (obs_add !== 2'd0) begin errors++; $display("FAIL twr_add got=%0d exp=0", obs_add); end
    checks++; if (obs_wdata !== 32'h9) begin errors++; $display("FAIL twr_wdata got=%h exp=9", obs_wdata); end
    checks++; if (obs_ack_cyc != 2) begin errors++; $display("FAIL twr_latency got=%0d exp=2", obs_ack_cyc); end
    checks++; if (obs_err !== 1'b0) begin errors++; $display("FAIL twr_err got=%b exp=0", obs_err); end
  endtask

  task automatic test_timer_read();
    dev_rdata = {32'h0000_0123, 32'($urandom)};
    bus_access(1'b0, 32'h0000_7F18, 4'h0, $urandom, -1, '0);
    checks++; if (obs_add !== 2'd2) begin errors++; $display("FAIL trd_add got=%0d exp=2", obs_add); end
    checks++; if (obs_rd !== 32'h123) begin errors++; $display("FAIL trd_rdata got=%h exp=123", obs_rd); end
    checks++; if (obs_we_cnt != 0) begin errors++; $display("FAIL trd_we got=%0d exp=0", obs_we_cnt); end
    checks++; if (obs_err !== 1'b0) begin errors++; $display("FAIL trd_err got=%b exp=0", obs_err); end
  endtask

  task automatic test_unmapped();
    dev_rdata = '1;
    bus_access(1'b0, 32'h0000_7F0C, 4'hF, 32'h0, -1, '0);
    checks++; if (obs_err !== 1'b1) begin errors++; $display("FAIL um_rd_err got=%b exp=1", obs_err); end
    checks++; if (obs_rd !== 32'h0) begin errors++; $display("FAIL um_rd_data got=%h exp=0", obs_rd); end
    checks++; if (obs_we_cnt != 0) begin errors++; $display("FAIL um_rd_we got=%0d exp=0", obs_we_cnt); end
    bus_access(1'b1, 32'h0000_8000, 4'hF, 32'hFFFF_FFFF, -1, '0);
    checks++; if (obs_err !== 1'b1) begin errors++; $display("FAIL um_wr_err got=%b exp=1", obs_err); end
    checks++; if (obs_we_cnt != 0) begin errors++; $display("FAIL um_wr_we got=%0d exp=0", obs_we_cnt); end
    bus_access(1'b0, 32'h0000_7F2C, 4'hF, 32'h0, -1, '0);
    checks++; if (obs_err !== 1'b1) begin errors++; $display("FAIL um_irqw3_err got=%b exp=1", obs_err); end
  endtask

  task automatic test_irq_path();
    bus_access(1'b1, 32'h0000_7F24, 4'hF, 32'h3, -1, '0);
    @(posedge CLK_I); #1; dev_irq = 2'b10;
    @(posedge CLK_I); #1; dev_irq = 2'b00;
    checks++; if (cpu_hwint !== 6'b0) begin errors++; $display("FAIL irq_hwint_early got=%b exp=000000", cpu_hwint); end
    @(posedge CLK_I); #1;
    checks++; if (cpu_hwint !== 6'b000010) begin errors++; $display("FAIL irq_hwint got=%b exp=000010", cpu_hwint); end
    bus_access(1'b0, 32'h0000_7F20, 4'hF, 32'h0, -1, '0);
    checks++; if (obs_rd !== 32'h2) begin errors++; $display("FAIL irq_pend_rd got=%h exp=2", obs_rd); end
    bus_access(1'b1, 32'h0000_7F20, 4'hF, 32'h2, -1, '0);
    checks++; if (cpu_hwint !== 6'b0) begin errors++; $display("FAIL irq_clr_hwint got=%b exp=0", cpu_hwint); end
    bus_access(1'b0, 32'h0000_7F20, 4'hF, 32'h0, -1, '0);
    checks++; if (obs_rd !== 32'h0) begin errors++; $display("FAIL irq_clr_pend got=%h exp=0", obs_rd); end
    // rising edge present during the XFER cycle of the clear
    bus_access(1'b1, 32'h0000_7F20, 4'hF, 32'h2, 1, 2'b10);
    dev_irq = 2'b00;
    bus_access(1'b0, 32'h0000_7F20, 4'hF, 32'h0, -1, '0);
    checks++; if (obs_rd !== 32'h2) begin errors++; $display("FAIL irq_set_wins got=%h exp=2", obs_rd); end
    checks++; if (cpu_hwint !== 6'b000010) begin errors++; $display("FAIL irq_set_wins_hwint got=%b exp=000010", cpu_hwint); end
    bus_access(1'b1, 32'h0000_7F20, 4'hF, 32'h3, -1, '0);
  endtask

  task automatic test_mask_level();
    bus_access(1'b1, 32'h0000_7F24, 4'hF, 32'h0, -1, '0);
    bus_access(1'b1, 32'h0000_7F20, 4'hF, 32'h3, -1, '0);
    dev_irq = 2'b01;
    repeat (3) begin @(posedge CLK_I); #1; end
    checks++; if (cpu_hwint !== 6'b0) begin errors++; $display("FAIL ml_masked_hwint got=%b exp=0", cpu_hwint); end
    bus_access(1'b0, 32'h0000_7F20, 4'hF, 32'h0, -1, '0);
    checks++; if (obs_rd !== 32'h1) begin errors++; $display("FAIL ml_pend got=%h exp=1", obs_rd); end
    bus_access(1'b1, 32'h0000_7F24, 4'hF, 32'h1, -1, '0);
    checks++; if (cpu_hwint !== 6'b000001) begin errors++; $display("FAIL ml_unmask_hwint got=%b exp=000001", cpu_hwint); end
    bus_access(1'b1, 32'h0000_7F20, 4'hF, 32'h1, -1, '0);
    repeat (3) begin @(posedge CLK_I); #1; end
    checks++; if (cpu_hwint !== 6'b0) begin errors++; $display("FAIL ml_level_hwint got=%b exp=0", cpu_hwint); end
    bus_access(1'b0, 32'h0000_7F20, 4'hF, 32'h0, -1, '0);
    checks++; if (obs_rd !== 32'h0) begin errors++; $display("FAIL ml_level_pend got=%h exp=0", obs_rd); end
    dev_irq = 2'b00;
    @(posedge CLK_I); #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] wd;
    logic [31:0] we_mask;
    logic [31:0] ack_mask;
    logic [31:0] exp_we_mask;
    logic [31:0] exp_ack_mask;
    logic [NDEV-1:0] we_val;
    logic [31:0] wd_seen;
    wd = $urandom; we_mask = '0; ack_mask = '0; we_val = '0; wd_seen = '0;
    exp_we_mask  = (32'd1 << 1) | (32'd1 << 4) | (32'd1 << 7);
    exp_ack_mask = (32'd1 << 2) | (32'd1 << 5) | (32'd1 << 8);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_7F14; cpu_be = 4'hF; cpu_wdata = wd;
    for (int c = 1; c <= 9; c++) begin
      @(posedge CLK_I); #1;
      if (dev_we !== '0) begin we_mask[c] = 1'b1; we_val = dev_we; wd_seen = dev_wdata; end
      if (cpu_ack === 1'b1) ack_mask[c] = 1'b1;
    end
    cpu_req = 1'b0;
    @(posedge CLK_I); #1;
    checks++; if (we_mask !== exp_we_mask) begin errors++; $display("FAIL b2b_we_cycles got=%h exp=%h", we_mask, exp_we_mask); end
    checks++; if (ack_mask !== exp_ack_mask) begin errors++; $display("FAIL b2b_ack_cycles got=%h exp=%h", ack_mask, exp_ack_mask); end
    checks++; if (we_val !== 2'b10) begin errors++; $display("FAIL b2b_we_val got=%b exp=10", we_val); end
    checks++; if (wd_seen !== wd) begin errors++; $display("FAIL b2b_wdata got=%h exp=%h", wd_seen, wd); end
  endtask

  task automatic test_reset_mid();
    int acks;
    bus_access(1'b1, 32'h0000_7F24, 4'hF, 32'h1, -1, '0);
    @(posedge CLK_I); #1; dev_irq = 2'b01;
    @(posedge CLK_I); #1; dev_irq = 2'b00;
    @(posedge CLK_I); #1;
    checks++; if (cpu_hwint !== 6'b000001) begin errors++; $display("FAIL rm_pre_hwint got=%b exp=000001", cpu_hwint); end
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_7F10; cpu_be = 4'hF; cpu_wdata = 32'h5;
    @(posedge CLK_I); #1;
    checks++; if (dev_we !== 2'b10) begin errors++; $display("FAIL rm_xfer_we got=%b exp=10", dev_we); end
    RST_I = 1'b1;
    @(posedge CLK_I); #1;
    RST_I = 1'b0; cpu_req = 1'b0;
    checks++; if (dev_we !== '0) begin errors++; $display("FAIL rm_we_after got=%b exp=0", dev_we); end
    checks++; if (cpu_hwint !== 6'b0) begin errors++; $display("FAIL rm_hwint got=%b exp=0", cpu_hwint); end
    acks = (cpu_ack === 1'b1) ? 1 : 0;
    repeat (4) begin @(posedge CLK_I); #1; if (cpu_ack === 1'b1) acks++; end
    checks++; if (acks != 0) begin errors++; $display("FAIL rm_no_ack got=%0d acks exp=0", acks); end
    bus_access(1'b0, 32'h0000_7F20, 4'hF, 32'h0, -1, '0);
    checks++; if (obs_rd !== 32'h0) begin errors++; $display("FAIL rm_pend got=%h exp=0", obs_rd); end
    checks++; if (obs_ack_cyc != 2 || obs_err !== 1'b0) begin errors++; $display("FAIL rm_next_req got ack_cyc=%0d err=%b exp 2/0", obs_ack_cyc, obs_err); end
    bus_access(1'b0, 32'h0000_7F24, 4'hF, 32'h0, -1, '0);
    checks++; if (obs_rd !== 32'h0) begin errors++; $display("FAIL rm_mask got=%h exp=0", obs_rd); end
  endtask

  task automatic test_random();
    logic [NDEV-1:0] m_pend, m_mask, m_irq, nirq, bm, exp_we;
    logic        we, exp_err, timer_hit;
    logic [3:0]  be;
    logic [31:0] wd, addr, off, exp_rd;
    int          slot, word;
    m_pend = '0; m_mask = '0; m_irq = dev_irq;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        nirq = NDEV'($urandom);
        m_pend = m_pend | (nirq & ~m_irq);
        m_irq = nirq; dev_irq = nirq;
        repeat (3) begin @(posedge CLK_I); #1; end
        checks++; if (cpu_hwint !== 6'(m_pend & m_mask)) begin errors++; $display("FAIL rnd_irq_hwint i=%0d got=%b exp=%b", i, cpu_hwint, 6'(m_pend & m_mask)); end
      end else begin
        we = 1'($urandom); be = 4'($urandom); wd = $urandom;
        case ($urandom_range(0, 4))
          0, 1:    addr = BASE + 32'(16 * $urandom_range(0, NDEV - 1)) + 32'($urandom_range(0, 15));
          2:       addr = BASE + 32'(16 * NDEV) + 32'($urandom_range(0, 15));
          3:       addr = BASE + 32'(16 * (NDEV + 1)) + 32'($urandom_range(0, 4095));
          default: addr = BASE - 32'($urandom_range(1, 4096));
        endcase
        for (int k = 0; k < int'(NDEV); k++) begin
          dev_rdata[32*k +: 32] = $urandom;
          bm[k] = be[k / 8];
        end
        off = addr - BASE;
        exp_err = 1'b1; exp_rd = '0; exp_we = '0; timer_hit = 1'b0; word = 0;
        if (off < 32'(16 * (NDEV + 1))) begin
          slot = int'(off) / 16;
          word = (int'(off) % 16) / 4;
          if (slot < int'(NDEV)) begin
            if (word != 3) begin
              exp_err = 1'b0; timer_hit = 1'b1;
              if (we) exp_we = NDEV'(1) << slot;
              else    exp_rd = dev_rdata[32*slot +: 32];
            end
          end else if (word == 0) begin
            exp_err = 1'b0;
            if (we) m_pend = m_pend & ~(wd[NDEV-1:0] & bm);
            else    exp_rd = 32'(m_pend);
          end else if (word == 1) begin
            exp_err = 1'b0;
            if (we) m_mask = (m_mask & ~bm) | (wd[NDEV-1:0] & bm);
            else    exp_rd = 32'(m_mask);
          end
        end
        bus_access(we, addr, be, wd, -1, '0);
        checks++; if (obs_ack_cyc != 2) begin errors++; $display("FAIL rnd_latency addr=%h got=%0d exp=2", addr, obs_ack_cyc); end
        checks++; if (obs_err !== exp_err) begin errors++; $display("FAIL rnd_err addr=%h got=%b exp=%b", addr, obs_err, exp_err); end
        checks++; if (obs_we_cnt != ((exp_we != '0) ? 1 : 0)) begin errors++; $display("FAIL rnd_we_cnt addr=%h we=%b got=%0d exp=%0d", addr, we, obs_we_cnt, (exp_we != '0) ? 1 : 0); end
        if (exp_we != '0) begin
          checks++; if (obs_we_val !== exp_we || obs_wdata !== wd) begin errors++; $display("FAIL rnd_we_val addr=%h got=%b/%h exp=%b/%h", addr, obs_we_val, obs_wdata, exp_we, wd); end
        end
        if (!we) begin
          checks++; if (obs_rd !== exp_rd) begin errors++; $display("FAIL rnd_rdata addr=%h got=%h exp=%h", addr, obs_rd, exp_rd); end
        end
        if (timer_hit) begin
          checks++; if (obs_add !== 2'(word)) begin errors++; $display("FAIL rnd_add addr=%h got=%0d exp=%0d", addr, obs_add, word); end
        end
        checks++; if (cpu_hwint !== 6'(m_pend & m_mask)) begin errors++; $display("FAIL rnd_hwint addr=%h got=%b exp=%b", addr, cpu_hwint, 6'(m_pend & m_mask)); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_timer_write();
    test_timer_read();
    test_unmapped();
    test_irq_path();
    test_mask_level();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete by 500000");
    $fatal(1);
  end

endmodule
